// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: ALU function codes and
// controller state encodings.
package alu_pkg;

    localparam logic [2:0] FN_FADD   = 3'd0;
    localparam logic [2:0] FN_ADD    = 3'd1;
    localparam logic [2:0] FN_XOR_OR = 3'd2;
    localparam logic [2:0] FN_NOR_R  = 3'd3;
    localparam logic [2:0] FN_NAND_R = 3'd4;
    localparam logic [2:0] FN_SHL    = 3'd5;
    localparam logic [2:0] FN_SHR    = 3'd6;
    localparam logic [2:0] FN_MUL    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, ties go to the requester that
// did not win last; the history bit only moves when the grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;
    logic win;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        win          = 1'b0;
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant_q;
            default: win = 1'b0;
        endcase
        if (req != 2'b00) begin
            grant = win ? 2'b10 : 2'b01;
            if (grant_en) begin
                last_grant_d = win;
            end
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            // NOTE: flops use non-blocking assignment so each one samples pre-edge values.
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one external combinational ALU and an accumulator between two
// requesters: IDLE grants and latches operands, EXEC lets the ALU settle, DONE acks.
module alu_req_scheduler
    import alu_pkg::*;
#(
    parameter int OPA_W = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [OPA_W-1:0] req_a0,
    input  logic [OPA_W-1:0] req_a1,
    input  logic [2:0]       req_func0,
    input  logic [2:0]       req_func1,
    input  logic [1:0]       req_wb,
    output logic [1:0]       ack,
    output logic [ACC_W-1:0] rsp_data,
    output logic             busy,
    output logic [OPA_W-1:0] alu_a,
    output logic [OPA_W-1:0] alu_b,
    output logic [2:0]       alu_func,
    input  logic [ACC_W-1:0] alu_result,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] ops_done
);

    state_e           state_q,    state_d;
    logic [OPA_W-1:0] alu_a_q,    alu_a_d;
    logic [2:0]       alu_func_q, alu_func_d;
    logic             wb_q,       wb_d;
    logic             gidx_q,     gidx_d;
    logic [ACC_W-1:0] res_q,      res_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [1:0]       ack_q,      ack_d;
    logic [CNT_W-1:0] ops_q,      ops_d;
    logic [1:0]       arb_grant;

    rr_arbiter2 u_arb (
        .clk      (clock_in),
        .rst_n    (reset_n),
        .req      (req),
        .grant_en (state_q == ST_IDLE),
        .grant    (arb_grant)
    );

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_func_d = alu_func_q;
        wb_d       = wb_q;
        gidx_d     = gidx_q;
        res_d      = res_q;
        acc_d      = acc_q;
        ack_d      = 2'b00;
        ops_d      = ops_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_grant != 2'b00) begin
                    gidx_d     = arb_grant[1];
                    alu_a_d    = arb_grant[1] ? req_a1 : req_a0;
                    alu_func_d = arb_grant[1] ? req_func1 : req_func0;
                    wb_d       = req_wb[arb_grant[1]];
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Ack, result and count are staged here so they are all visible during DONE.
                res_d = alu_result;
                if (wb_q) begin
                    acc_d = alu_result;
                end
                ack_d   = gidx_q ? 2'b10 : 2'b01;
                ops_d   = ops_q + CNT_W'(1);
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_func_q <= '0;
            wb_q       <= 1'b0;
            gidx_q     <= 1'b0;
            res_q      <= '0;
            acc_q      <= '0;
            ack_q      <= 2'b00;
            ops_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_func_q <= alu_func_d;
            wb_q       <= wb_d;
            gidx_q     <= gidx_d;
            res_q      <= res_d;
            acc_q      <= acc_d;
            ack_q      <= ack_d;
            ops_q      <= ops_d;
        end
    end

    assign ack      = ack_q;
    assign rsp_data = res_q;
    assign busy     = (state_q != ST_IDLE);
    assign alu_a    = alu_a_q;
    assign alu_b    = acc_q[OPA_W-1:0];
    assign alu_func = alu_func_q;
    assign acc      = acc_q;
    assign ops_done = ops_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler: drives two requesters, models the
// external ALU, and compares every ack against queued expectations.
module tb_alu_req_scheduler;
    import alu_pkg::*;

    logic       clock_in = 1'b0;
    logic       reset_n  = 1'b0;
    logic [1:0] req      = 2'b00;
    logic [3:0] req_a0   = '0;
    logic [3:0] req_a1   = '0;
    logic [2:0] req_func0 = '0;
    logic [2:0] req_func1 = '0;
    logic [1:0] req_wb   = 2'b00;
    logic [1:0] ack;
    logic [7:0] rsp_data;
    logic       busy;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_func;
    logic [7:0] alu_result;
    logic [7:0] acc;
    logic [7:0] ops_done;

    alu_req_scheduler dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .req        (req),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_func0  (req_func0),
        .req_func1  (req_func1),
        .req_wb     (req_wb),
        .ack        (ack),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .acc        (acc),
        .ops_done   (ops_done)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] f);
        logic [7:0] aw;
        logic [7:0] bw;
        aw = {4'b0, a};
        bw = {4'b0, b};
        case (f)
            FN_FADD:   alu_ref = aw + bw + 8'd1;
            FN_ADD:    alu_ref = aw + bw;
            FN_XOR_OR: alu_ref = {a ^ b, a | b};
            FN_NOR_R:  alu_ref = {7'b0, ~|{a, b}};
            FN_NAND_R: alu_ref = {7'b0, ~&{a, b}};
            FN_SHL:    alu_ref = bw << a;
            FN_SHR:    alu_ref = bw >> a;
            default:   alu_ref = aw * bw;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_a, alu_b, alu_func);

    typedef struct {
        logic [1:0] ack;
        logic [7:0] data;
        logic [7:0] acc;
        logic [7:0] ops;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] m_acc = '0;
    logic [7:0] m_ops = '0;
    logic       m_lg  = 1'b1;
    logic [7:0] last_rsp = '0;
    logic [1:0] ack_prev = 2'b00;
    logic [1:0] first_ack_mask;
    int         first_ack_cyc;
    int         last_ack_cyc;

    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every ack pops one expectation; the cycle after an ack must be IDLE.
    always @(negedge clock_in) begin
        if (reset_n) begin
            if (ack != 2'b00) begin
                check("ack_onehot", $countones(ack), 1);
                check("ack_busy", busy, 1);
                if (sb.size() == 0) begin
                    check("ack_unexpected", ack, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_idx", ack, e.ack);
                    check("rsp_data", rsp_data, e.data);
                    check("acc", acc, e.acc);
                    check("ops_done", ops_done, e.ops);
                end
                last_rsp <= rsp_data;
            end
            if (ack_prev != 2'b00) check("busy_idle", busy, 0);
            ack_prev <= ack;
        end else begin
            ack_prev <= 2'b00;
        end
    end

    task automatic set_opnd(input logic idx, input logic [3:0] a, input logic [2:0] f,
                            input logic wb);
        if (idx) begin
            req_a1    = a;
            req_func1 = f;
        end else begin
            req_a0    = a;
            req_func0 = f;
        end
        req_wb[idx] = wb;
    endtask

    task automatic push_exp(input logic idx, input logic [3:0] a, input logic [2:0] f,
                            input logic wb);
        exp_t e;
        e.data = alu_ref(a, m_acc[3:0], f);
        if (wb) m_acc = e.data;
        m_ops = m_ops + 8'd1;
        m_lg  = idx;
        e.ack = idx ? 2'b10 : 2'b01;
        e.acc = m_acc;
        e.ops = m_ops;
        sb.push_back(e);
    endtask

    // Waits (bounded) for each requester in mask to be acked, dropping its req
    // on the edge that follows the observed ack.
    task automatic wait_acks(input logic [1:0] mask);
        logic [1:0] pending;
        logic [1:0] got;
        int         n;
        pending        = mask;
        n              = 0;
        first_ack_cyc  = -1;
        last_ack_cyc   = -1;
        first_ack_mask = 2'b00;
        while (pending != 2'b00 && n < 40) begin
            @(negedge clock_in);
            n++;
            got = ack & pending;
            if (got != 2'b00) begin
                if (first_ack_cyc < 0) begin
                    first_ack_cyc  = cyc;
                    first_ack_mask = got;
                end
                last_ack_cyc = cyc;
                @(posedge clock_in);
                #1;
                req     = req & ~got;
                pending = pending & ~got;
            end
        end
        check("ack_arrived", pending, 2'b00);
    endtask

    // Called at posedge+#1 with the DUT idle.
    task automatic do_op(input logic idx, input logic [3:0] a, input logic [2:0] f,
                         input logic wb);
        int         c0;
        logic [3:0] b_pre;
        set_opnd(idx, a, f, wb);
        b_pre = m_acc[3:0];
        push_exp(idx, a, f, wb);
        req[idx] = 1'b1;
        c0 = cyc;
        @(posedge clock_in);
        @(negedge clock_in);
        check("exec_busy", busy, 1);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_func", alu_func, f);
        check("exec_alu_b", alu_b, b_pre);
        wait_acks(idx ? 2'b10 : 2'b01);
        check("latency", first_ack_cyc - c0, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       win;
        logic       r_idx;
        logic [3:0] r_a;
        logic [2:0] r_f;
        logic       r_wb;

        repeat (2) @(negedge clock_in);
        check("rst_ack", ack, 2'b00);
        check("rst_rsp", rsp_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 4'h0);
        check("rst_alu_func", alu_func, 3'd0);
        check("rst_acc", acc, 8'h00);
        check("rst_ops", ops_done, 8'h00);
        reset_n = 1'b1;
        @(posedge clock_in);
        #1;

        do_op(1'b0, 4'h5, FN_ADD, 1'b1);
        check("add_rsp", last_rsp, 8'h05);
        check("add_acc", acc, 8'h05);
        check("add_ops", ops_done, 8'd1);

        do_op(1'b1, 4'h3, FN_MUL, 1'b1);
        check("mul_rsp", last_rsp, 8'h0F);
        check("mul_acc", acc, 8'h0F);

        // Both requesters at once; write-back off so acc stays 0x0F.
        set_opnd(1'b0, 4'h9, FN_XOR_OR, 1'b0);
        set_opnd(1'b1, 4'h6, FN_ADD, 1'b0);
        win = ~m_lg;
        push_exp(win, win ? 4'h6 : 4'h9, win ? FN_ADD : FN_XOR_OR, 1'b0);
        push_exp(~win, win ? 4'h9 : 4'h6, win ? FN_XOR_OR : FN_ADD, 1'b0);
        req = 2'b11;
        wait_acks(2'b11);
        check("cont_first", first_ack_mask, 2'b01);
        check("cont_gap", last_ack_cyc - first_ack_cyc, 3);

        do_op(1'b0, 4'h2, FN_SHL, 1'b0);
        check("shl_rsp", last_rsp, 8'h3C);
        check("shl_acc", acc, 8'h0F);
        do_op(1'b1, 4'h1, FN_SHR, 1'b1);
        check("shr_rsp", last_rsp, 8'h07);
        check("shr_acc", acc, 8'h07);

        // Abort an op in EXEC with reset.
        set_opnd(1'b0, 4'h7, FN_ADD, 1'b1);
        req[0] = 1'b1;
        @(posedge clock_in);
        @(negedge clock_in);
        check("abort_in_exec", busy, 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ack", ack, 2'b00);
        check("abort_acc", acc, 8'h00);
        check("abort_ops", ops_done, 8'h00);
        req   = 2'b00;
        m_acc = '0;
        m_ops = '0;
        m_lg  = 1'b1;
        @(negedge clock_in);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock_in);
            check("abort_no_ack", ack, 2'b00);
        end
        @(posedge clock_in);
        #1;

        do_op(1'b0, 4'h3, FN_FADD, 1'b1);
        check("fadd_acc", acc, 8'h04);
        check("fadd_ops", ops_done, 8'd1);

        for (int i = 0; i < 255; i++) begin
            r_idx = 1'($urandom_range(0, 1));
            r_a   = 4'($urandom_range(0, 15));
            r_f   = 3'($urandom_range(0, 7));
            r_wb  = 1'($urandom_range(0, 1));
            do_op(r_idx, r_a, r_f, r_wb);
        end
        check("ops_wrap", ops_done, 8'h00);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Controller that shares one combinational 8-function ALU and an 8-bit accumulator between two requesters.
- Arbitrates requests round-robin, drives the ALU operands and function code, and writes the result back into the accumulator.
- Returns the result to the granted requester with a one-cycle ack pulse.
- Sits between board-level/user request sources (switch/key front-ends) and the ALU; the accumulator low nibble feeds ALU operand B.

Parameters:
- OPA_W, 4, width of operand A and of ALU operand B (B = acc[OPA_W-1:0]).
- ACC_W, 8, width of ALU result, accumulator and response data.
- CNT_W, 8, width of completed-operation counter.

Ports:
- clock_in  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request level; held until the matching ack.
- req_a0 / req_a1  in  OPA_W  operand A from requester 0 / 1.
- req_func0 / req_func1  in  3  ALU function code from requester 0 / 1.
- req_wb  in  2  per-requester write-back enable (1 = update accumulator).
- ack  out  2  one-cycle completion pulse, one-hot to the granted requester.
- rsp_data  out  ACC_W  result of the completed op; valid while any ack bit is 1.
- busy  out  1  high in EXEC and DONE.
- alu_a  out  OPA_W  ALU operand A (registered).
- alu_b  out  OPA_W  ALU operand B = acc[OPA_W-1:0].
- alu_func  out  3  ALU function select (registered).
- alu_result  in  ACC_W  combinational ALU output.
- acc  out  ACC_W  accumulator value.
- ops_done  out  CNT_W  count of completed operations.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, acc=0, ack=0, rsp_data=0, busy=0, alu_a=0, alu_func=0, ops_done=0, last_grant=1 (requester 0 wins the first tie).
- FSM states:
  - IDLE: if req!=0, grant and latch the winner's a/func/wb into alu_a/alu_func/wb_q, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: one cycle for the ALU to settle. At the end of the cycle, capture alu_result into res_q; if wb_q=1, also write acc<=alu_result. Go to DONE.
  - DONE: ack[grant]=1 for exactly this cycle, rsp_data=res_q, ops_done increments (wraps modulo 2^CNT_W). Go to IDLE.
- Latency: request sampled at edge N, result at edge N+1, ack high during cycle N+1 to N+2. Throughput is one op per 3 cycles.
- Arbitration: only one requester active → grant it. Both active → grant !last_grant. last_grant updates on every grant.
- Handshake: requester deasserts req on the edge at which it observes ack=1. req still high in IDLE after an ack is a new request. Changes to req or operands during EXEC/DONE are ignored (operands latched at grant).
- alu_b always reflects the current acc. A write-back op therefore uses the pre-op acc as B, and the new acc appears from DONE onward.
- Function codes: 0 full-add, 1 add, 2 xor/or, 3 nor-reduce, 4 nand-reduce, 5 shl, 6 shr, 7 mul. Result width is ACC_W with no saturation; mul of 4x4 fits in 8 bits.
- req_wb=0: result is returned, acc is unchanged, ops_done still increments.
- Reset mid-op (EXEC or DONE): op is aborted, no ack is issued, acc=0; the requester must re-request.
- ack bits are never both 1. ack is never asserted outside DONE.

Decomposition:
- Shared package alu_pkg: 3-bit function-code constants FN_FADD..FN_MUL and FSM state encodings ST_IDLE/ST_EXEC/ST_DONE.
- One natural sub-module: rr_arbiter2 (2-way round-robin, last_grant register, one-hot grant). The ALU stays external.

Test Plan:
- Single op: after reset, req[0]=1, a0=5, func0=1, wb0=1 → ack[0] two edges later, rsp_data=0x05, acc=0x05, ops_done=1.
- Multiply: acc=0x05, req[1], a1=3, func1=7, wb1=1 → alu_b=5, rsp_data=0x0F, acc=0x0F, ack[1] only.
- Contention: last_grant=1, both req high → requester 0 served first, then 1; exactly 2 acks 3 cycles apart, never simultaneous.
- Shift/no write-back: acc=0x0F, func=5, a=2, wb=0 → rsp_data=0x3C, acc stays 0x0F; then func=6, a=1, wb=1 → rsp_data=0x07, acc=0x07.
- Reset mid-EXEC: pull reset_n low during EXEC → immediate IDLE, acc=0, no ack, ops_done=0; normal op succeeds afterwards.
- Counter wrap: 256 completed ops → ops_done returns to 0; busy low in every IDLE cycle.
